// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bundle: two requesters (ALU on req0, load on req1) sharing one RF write port.
// The master modport is the requester side; the slave modport is the arbiter side.
interface rf_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the register-file write port; writes to r0 are accepted then dropped.
// Define RF_WB_FWD_EN to add two read-side bypass channels fed from the registered write.
module rf_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              freeze,
    rf_wb_arbiter_if.slave    req,
    output logic              w_en,
    output logic [ADDR_W-1:0] addr_w,
    output logic [DATA_W-1:0] w_data,
    output logic              zero_drop,
    output logic [CNT_W-1:0]  conflict_cnt
`ifdef RF_WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0] fwd_addr_1,
    input  logic [ADDR_W-1:0] fwd_addr_2,
    output logic              fwd_hit_1,
    output logic              fwd_hit_2,
    output logic [DATA_W-1:0] fwd_data_1,
    output logic [DATA_W-1:0] fwd_data_2
`endif
);

    typedef enum logic {
        IDLE_PRI0 = 1'b0,
        IDLE_PRI1 = 1'b1
    } rr_state_e;

    rr_state_e         rr_q, rr_d;
    logic              w_en_q, w_en_d;
    logic [ADDR_W-1:0] addr_w_q, addr_w_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic              zero_drop_q, zero_drop_d;
    logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

    logic              gnt0, gnt1, xfer, xfer_zero, both_valid;
    logic [ADDR_W-1:0] xfer_addr;
    logic [DATA_W-1:0] xfer_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        both_valid = req.req0_valid & req.req1_valid;
        gnt0 = ~freeze & req.req0_valid & (~req.req1_valid | (rr_q == IDLE_PRI0));
        gnt1 = ~freeze & req.req1_valid & (~req.req0_valid | (rr_q == IDLE_PRI1));
        xfer      = gnt0 | gnt1;
        xfer_addr = gnt1 ? req.req1_addr : req.req0_addr;
        xfer_data = gnt1 ? req.req1_data : req.req0_data;
        xfer_zero = xfer & (xfer_addr == '0);

        rr_d = rr_q;
        if (gnt0)      rr_d = IDLE_PRI1;
        else if (gnt1) rr_d = IDLE_PRI0;

        // Address/data only move on a real write so the RF port sees stable values otherwise.
        w_en_d      = xfer & ~xfer_zero;
        addr_w_d    = w_en_d ? xfer_addr : addr_w_q;
        w_data_d    = w_en_d ? xfer_data : w_data_q;
        zero_drop_d = xfer_zero;

        conflict_cnt_d = (both_valid & ~freeze) ? sat_inc(conflict_cnt_q) : conflict_cnt_q;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rr_q           <= IDLE_PRI0;
            w_en_q         <= 1'b0;
            addr_w_q       <= '0;
            w_data_q       <= '0;
            zero_drop_q    <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            rr_q           <= rr_d;
            w_en_q         <= w_en_d;
            addr_w_q       <= addr_w_d;
            w_data_q       <= w_data_d;
            zero_drop_q    <= zero_drop_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Readys are masked during reset so no requester sees a phantom acceptance.
    assign req.req0_ready = gnt0 & ~arst;
    assign req.req1_ready = gnt1 & ~arst;

    assign w_en         = w_en_q;
    assign addr_w       = addr_w_q;
    assign w_data       = w_data_q;
    assign zero_drop    = zero_drop_q;
    assign conflict_cnt = conflict_cnt_q;

`ifdef RF_WB_FWD_EN
    assign fwd_hit_1  = w_en_q & (addr_w_q == fwd_addr_1) & (fwd_addr_1 != '0);
    assign fwd_hit_2  = w_en_q & (addr_w_q == fwd_addr_2) & (fwd_addr_2 != '0);
    assign fwd_data_1 = fwd_hit_1 ? w_data_q : '0;
    assign fwd_data_2 = fwd_hit_2 ? w_data_q : '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter; inputs change on the falling edge, outputs sampled 1 ns after edges.
module tb_rf_wb_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              arst;
    logic              freeze;
    logic              w_en;
    logic [ADDR_W-1:0] addr_w;
    logic [DATA_W-1:0] w_data;
    logic              zero_drop;
    logic [CNT_W-1:0]  conflict_cnt;
`ifdef RF_WB_FWD_EN
    logic [ADDR_W-1:0] fwd_addr_1, fwd_addr_2;
    logic              fwd_hit_1, fwd_hit_2;
    logic [DATA_W-1:0] fwd_data_1, fwd_data_2;
`endif

    int vecs = 0;
    int miscompares = 0;

    rf_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .arst(arst), .freeze(freeze), .req(bus.slave),
        .w_en(w_en), .addr_w(addr_w), .w_data(w_data),
        .zero_drop(zero_drop), .conflict_cnt(conflict_cnt)
`ifdef RF_WB_FWD_EN
        , .fwd_addr_1(fwd_addr_1), .fwd_addr_2(fwd_addr_2),
        .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2),
        .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2)
`endif
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); arst = 1'b1; idle_inputs(); freeze = 1'b0;
        @(negedge clk); arst = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1; freeze = 1'b0; idle_inputs();
        bus.req0_valid = 1'b1; bus.req0_addr = 6'd10; bus.req0_data = 32'hA5A5;
        bus.req1_valid = 1'b1; bus.req1_addr = 6'd11; bus.req1_data = 32'hB6B6;
        @(posedge clk); #1;
        vecs++; if (w_en !== 1'b0) begin miscompares++; $display("FAIL rst_w_en: got %0h want 0", w_en); end
        vecs++; if (addr_w !== 6'd0) begin miscompares++; $display("FAIL rst_addr_w: got %0h want 0", addr_w); end
        vecs++; if (w_data !== 32'd0) begin miscompares++; $display("FAIL rst_w_data: got %0h want 0", w_data); end
        vecs++; if (zero_drop !== 1'b0) begin miscompares++; $display("FAIL rst_zero_drop: got %0h want 0", zero_drop); end
        vecs++; if (conflict_cnt !== 4'd0) begin miscompares++; $display("FAIL rst_cnt: got %0d want 0", conflict_cnt); end
        vecs++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %0b%0b want 00", bus.req0_ready, bus.req1_ready); end
        @(negedge clk); arst = 1'b0; #1;
        vecs++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready0: got %0h want 1", bus.req0_ready); end
        @(posedge clk); #1;
        vecs++; if (w_en !== 1'b1 || addr_w !== 6'd10) begin miscompares++; $display("FAIL pre_arst_write: got w_en=%0h addr=%0d want 1/10", w_en, addr_w); end
        vecs++; if (conflict_cnt !== 4'd1) begin miscompares++; $display("FAIL pre_arst_cnt: got %0d want 1", conflict_cnt); end
        // Mid-cycle asynchronous reset with req0 still requesting.
        #2; arst = 1'b1; #1;
        vecs++; if (w_en !== 1'b0) begin miscompares++; $display("FAIL arst_w_en: got %0h want 0", w_en); end
        vecs++; if (conflict_cnt !== 4'd0) begin miscompares++; $display("FAIL arst_cnt: got %0d want 0", conflict_cnt); end
        vecs++; if (bus.req0_ready !== 1'b0) begin miscompares++; $display("FAIL arst_ready0: got %0h want 0", bus.req0_ready); end
        @(negedge clk); arst = 1'b0; bus.req1_valid = 1'b0; #1;
        vecs++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("FAIL retry_ready0: got %0h want 1", bus.req0_ready); end
        @(posedge clk); #1;
        vecs++; if (w_en !== 1'b1 || addr_w !== 6'd10 || w_data !== 32'hA5A5) begin miscompares++; $display("FAIL retry_write: got %0h/%0d/%0h want 1/10/a5a5", w_en, addr_w, w_data); end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_single();
        pulse_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 6'd5; bus.req0_data = 32'hDEADBEEF; #1;
        vecs++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin miscompares++; $display("FAIL single_ready: got %0b%0b want 10", bus.req0_ready, bus.req1_ready); end
        @(posedge clk); #1;
        vecs++; if (w_en !== 1'b1 || addr_w !== 6'd5 || w_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_write: got %0h/%0d/%0h want 1/5/deadbeef", w_en, addr_w, w_data); end
        @(negedge clk); idle_inputs();
        @(posedge clk); #1;
        vecs++; if (w_en !== 1'b0) begin miscompares++; $display("FAIL single_w_en_off: got %0h want 0", w_en); end
        vecs++; if (addr_w !== 6'd5 || w_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_hold: got %0d/%0h want 5/deadbeef", addr_w, w_data); end
    endtask

    task automatic test_contention();
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_data;
        pulse_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 6'd3; bus.req0_data = 32'h30;
        bus.req1_valid = 1'b1; bus.req1_addr = 6'd4; bus.req1_data = 32'h40;
        for (int i = 0; i < 4; i++) begin
            #1;
            vecs++; if (bus.req0_ready !== (i % 2 == 0) || bus.req1_ready !== (i % 2 == 1)) begin miscompares++; $display("FAIL cont_ready[%0d]: got %0b%0b", i, bus.req0_ready, bus.req1_ready); end
            exp_addr = (i % 2 == 0) ? 6'd3 : 6'd4;
            exp_data = (i % 2 == 0) ? 32'h30 : 32'h40;
            @(posedge clk); #1;
            vecs++; if (w_en !== 1'b1 || addr_w !== exp_addr || w_data !== exp_data) begin miscompares++; $display("FAIL cont_write[%0d]: got %0h/%0d/%0h want 1/%0d/%0h", i, w_en, addr_w, w_data, exp_addr, exp_data); end
            @(negedge clk);
        end
        idle_inputs();
        vecs++; if (conflict_cnt !== 4'd4) begin miscompares++; $display("FAIL cont_cnt: got %0d want 4", conflict_cnt); end
    endtask

    task automatic test_zero();
        @(negedge clk);
        bus.req1_valid = 1'b1; bus.req1_addr = 6'd0; bus.req1_data = 32'h1234; #1;
        vecs++; if (bus.req1_ready !== 1'b1) begin miscompares++; $display("FAIL zero_ready1: got %0h want 1", bus.req1_ready); end
        @(posedge clk); #1;
        vecs++; if (w_en !== 1'b0 || zero_drop !== 1'b1) begin miscompares++; $display("FAIL zero_drop1: got w_en=%0h zd=%0h want 0/1", w_en, zero_drop); end
        @(negedge clk); idle_inputs();
        @(posedge clk); #1;
        vecs++; if (zero_drop !== 1'b0 || w_en !== 1'b0) begin miscompares++; $display("FAIL zero_pulse_end: got zd=%0h w_en=%0h want 0/0", zero_drop, w_en); end
        // A dropped req0 write must still hand priority to req1.
        @(negedge clk); bus.req0_valid = 1'b1; bus.req0_addr = 6'd0; bus.req0_data = 32'h77; #1;
        vecs++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("FAIL zero_ready0: got %0h want 1", bus.req0_ready); end
        @(posedge clk); #1;
        vecs++; if (zero_drop !== 1'b1 || w_en !== 1'b0) begin miscompares++; $display("FAIL zero_drop0: got zd=%0h w_en=%0h want 1/0", zero_drop, w_en); end
        @(negedge clk);
        bus.req0_addr = 6'd3; bus.req0_data = 32'h30;
        bus.req1_valid = 1'b1; bus.req1_addr = 6'd4; bus.req1_data = 32'h40; #1;
        vecs++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1) begin miscompares++; $display("FAIL zero_rr_adv: got %0b%0b want 01", bus.req0_ready, bus.req1_ready); end
        @(posedge clk); #1;
        vecs++; if (addr_w !== 6'd4 || zero_drop !== 1'b0) begin miscompares++; $display("FAIL zero_then_w: got addr=%0d zd=%0h want 4/0", addr_w, zero_drop); end
        @(negedge clk); bus.req1_valid = 1'b0; #1;
        vecs++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("FAIL zero_r0_after: got %0h want 1", bus.req0_ready); end
        @(posedge clk); #1;
        vecs++; if (addr_w !== 6'd3 || w_data !== 32'h30) begin miscompares++; $display("FAIL zero_r0_write: got %0d/%0h want 3/30", addr_w, w_data); end
        @(negedge clk); idle_inputs();
        vecs++; if (conflict_cnt !== 4'd5) begin miscompares++; $display("FAIL zero_cnt: got %0d want 5", conflict_cnt); end
    endtask

    task automatic test_freeze();
        @(negedge clk);
        freeze = 1'b1; bus.req1_valid = 1'b1; bus.req1_addr = 6'd9; bus.req1_data = 32'h99;
        for (int i = 0; i < 3; i++) begin
            #1;
            vecs++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin miscompares++; $display("FAIL frz_ready[%0d]: got %0b%0b want 00", i, bus.req0_ready, bus.req1_ready); end
            @(posedge clk); #1;
            vecs++; if (w_en !== 1'b0 || conflict_cnt !== 4'd5) begin miscompares++; $display("FAIL frz_out[%0d]: got w_en=%0h cnt=%0d want 0/5", i, w_en, conflict_cnt); end
            @(negedge clk);
        end
        freeze = 1'b0; #1;
        vecs++; if (bus.req1_ready !== 1'b1) begin miscompares++; $display("FAIL frz_release: got %0h want 1", bus.req1_ready); end
        @(posedge clk); #1;
        vecs++; if (w_en !== 1'b1 || addr_w !== 6'd9 || w_data !== 32'h99) begin miscompares++; $display("FAIL frz_write: got %0h/%0d/%0h want 1/9/99", w_en, addr_w, w_data); end
        // Both valid while frozen: no conflict counted.
        @(negedge clk);
        freeze = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_addr = 6'd12; bus.req0_data = 32'hC0;
        bus.req1_valid = 1'b1; bus.req1_addr = 6'd13; bus.req1_data = 32'hD0;
        repeat (2) @(posedge clk);
        #1;
        vecs++; if (conflict_cnt !== 4'd5 || w_en !== 1'b0) begin miscompares++; $display("FAIL frz_both: got cnt=%0d w_en=%0h want 5/0", conflict_cnt, w_en); end
        @(negedge clk); freeze = 1'b0; #1;
        vecs++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin miscompares++; $display("FAIL frz_both_rel: got %0b%0b want 10", bus.req0_ready, bus.req1_ready); end
        @(posedge clk); #1;
        vecs++; if (conflict_cnt !== 4'd6 || addr_w !== 6'd12) begin miscompares++; $display("FAIL frz_both_cnt: got cnt=%0d addr=%0d want 6/12", conflict_cnt, addr_w); end
        @(negedge clk); bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        vecs++; if (addr_w !== 6'd13 || w_data !== 32'hD0) begin miscompares++; $display("FAIL frz_both_r1: got %0d/%0h want 13/d0", addr_w, w_data); end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [CNT_W-1:0]  exp_cnt;
        logic [ADDR_W-1:0] exp_addr;
        pulse_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 6'd1; bus.req0_data = 32'h11;
        bus.req1_valid = 1'b1; bus.req1_addr = 6'd2; bus.req1_data = 32'h22;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            exp_cnt  = (i < 15) ? 4'(i + 1) : 4'd15;
            exp_addr = (i % 2 == 0) ? 6'd1 : 6'd2;
            vecs++; if (conflict_cnt !== exp_cnt) begin miscompares++; $display("FAIL b2b_cnt[%0d]: got %0d want %0d", i, conflict_cnt, exp_cnt); end
            vecs++; if (w_en !== 1'b1 || addr_w !== exp_addr) begin miscompares++; $display("FAIL b2b_write[%0d]: got %0h/%0d want 1/%0d", i, w_en, addr_w, exp_addr); end
        end
        @(negedge clk); idle_inputs();
    endtask

`ifdef RF_WB_FWD_EN
    task automatic test_fwd();
        pulse_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 6'd7; bus.req0_data = 32'h55;
        fwd_addr_1 = 6'd7; fwd_addr_2 = 6'd0;
        @(posedge clk); #1;
        vecs++; if (fwd_hit_1 !== 1'b1 || fwd_data_1 !== 32'h55) begin miscompares++; $display("FAIL fwd1: got %0h/%0h want 1/55", fwd_hit_1, fwd_data_1); end
        vecs++; if (fwd_hit_2 !== 1'b0 || fwd_data_2 !== 32'h0) begin miscompares++; $display("FAIL fwd2_r0: got %0h/%0h want 0/0", fwd_hit_2, fwd_data_2); end
        fwd_addr_2 = 6'd7; #1;
        vecs++; if (fwd_hit_2 !== 1'b1 || fwd_data_2 !== 32'h55) begin miscompares++; $display("FAIL fwd2: got %0h/%0h want 1/55", fwd_hit_2, fwd_data_2); end
        @(negedge clk); idle_inputs();
        @(posedge clk); #1;
        vecs++; if (fwd_hit_1 !== 1'b0 || fwd_data_1 !== 32'h0) begin miscompares++; $display("FAIL fwd1_off: got %0h/%0h want 0/0", fwd_hit_1, fwd_data_1); end
    endtask
`endif

    initial begin
`ifdef RF_WB_FWD_EN
        fwd_addr_1 = '0; fwd_addr_2 = '0;
`endif
        test_reset();
        test_single();
        test_contention();
        test_zero();
        test_freeze();
        test_back_to_back();
`ifdef RF_WB_FWD_EN
        test_fwd();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
